dac_sampler_mc: RTL and testbench

//  Multi-channel successor to the two-channel DAC sample-and-hold. Captures NUM_CH Zmod
//  DAC channels plus the IAGC status word on i_sample strobes, with programmable

---
 rtl/dac_sampler_mc_pkg.sv | 41 ++++
 rtl/dac_sampler_mc_if.sv | 48 ++++
 rtl/dac_avg_channel.sv | 55 +++++
 rtl/dac_sampler_mc.sv | 166 ++++++++++++++++
 tb/tb_dac_sampler_mc.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_sampler_mc_pkg.sv
// ============================================================================
// Module      : dac_sampler_mc_pkg
// Description : Shared definitions for the multi-channel DAC sampler: FSM state
//               encodings and small constant helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dac_sampler_mc_pkg;

   // FSM state encoding (explicit width)
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Ceiling log2 with a floor of 1 so the result can always size a vector.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

   // Clamp an averaging exponent to the largest supported value.
   function automatic int unsigned clamp_log2(input int unsigned value,
                                              input int unsigned max_val);
      return (value > max_val) ? max_val : value;
   endfunction

   // Accumulator width: sample width plus headroom for 2^max_log2 additions.
   function automatic int acc_width(input int data_w, input int max_log2);
      return data_w + max_log2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dac_sampler_mc_if.sv
// ============================================================================
// Module      : dac_sampler_mc_if
// Description : Sample input and result handshake bundle of the sampler.
//               master : sampler side (drives o_* results, reads i_* controls)
//               slave  : environment side (drives i_*, reads o_*)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dac_sampler_mc_if
   import dac_sampler_mc_pkg::*;
#(
   parameter int ZMOD_DATA_SIZE   = 14,
   parameter int IAGC_STATUS_SIZE = 4,
   parameter int NUM_CH           = 2,
   parameter int DECIM_W          = 8,
   parameter int AVG_LOG2_MAX     = 3
);
   localparam int AVG_W = clog2(AVG_LOG2_MAX + 1);

   logic                             i_enable;
   logic [NUM_CH*ZMOD_DATA_SIZE-1:0] i_data;
   logic [IAGC_STATUS_SIZE-1:0]      i_iagc_status;
   logic                             i_sample;
   logic [DECIM_W-1:0]               i_decim;
   logic [AVG_W-1:0]                 i_avg_log2;
   logic [NUM_CH*ZMOD_DATA_SIZE-1:0] o_data;
   logic [IAGC_STATUS_SIZE-1:0]      o_iagc_status;
   logic                             o_valid;
   logic                             i_ready;
   logic                             o_overrun;
   logic                             i_clear_overrun;

   modport master (
      input  i_enable, i_data, i_iagc_status, i_sample, i_decim, i_avg_log2,
      input  i_ready, i_clear_overrun,
      output o_data, o_iagc_status, o_valid, o_overrun
   );

   modport slave (
      output i_enable, i_data, i_iagc_status, i_sample, i_decim, i_avg_log2,
      output i_ready, i_clear_overrun,
      input  o_data, o_iagc_status, o_valid, o_overrun
   );

endinterface

`default_nettype wire

// File: rtl/dac_avg_channel.sv
// ============================================================================
// Module      : dac_avg_channel
// Description : One channel of block averaging: signed accumulator plus an
//               arithmetic right shift producing the block mean.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drop the running sum
//   accumulate  : add the current sample
//   complete    : this sample closes the block (sum restarts at 0)
//   shift       : averaging exponent for the closing block
//   sample      : two's complement input sample
//   result      : (running sum + sample) >>> shift, valid when complete
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_avg_channel #(
   parameter int DATA_W  = 14,
   parameter int ACC_W   = 17,
   parameter int SHIFT_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               accumulate,
   input  logic               complete,
   input  logic [SHIFT_W-1:0] shift,
   input  logic [DATA_W-1:0]  sample,
   output logic [DATA_W-1:0]  result
);
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_ext;
   logic signed [ACC_W-1:0] w_sum;

   always_comb begin
      w_ext              = {ACC_W{sample[DATA_W-1]}};
      w_ext[DATA_W-1:0]  = sample;
   end

   assign w_sum  = r_acc + w_ext;
   // Arithmetic shift floors toward -inf; the mean always fits DATA_W bits.
   assign result = DATA_W'(w_sum >>> shift);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (clear) begin
         r_acc <= '0;
      end else if (accumulate) begin
         r_acc <= complete ? '0 : w_sum;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dac_sampler_mc.sv
// ============================================================================
// Module      : dac_sampler_mc
// Description : Multi-channel DAC sample capture with decimation, power-of-two
//               block averaging and a valid/ready result register.
//   i_clock, i_reset_n : clock, asynchronous active-low reset
//   bus (master)       : sample inputs, config, result handshake, overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_sampler_mc
   import dac_sampler_mc_pkg::*;
#(
   parameter int ZMOD_DATA_SIZE   = 14,
   parameter int IAGC_STATUS_SIZE = 4,
   parameter int NUM_CH           = 2,
   parameter int DECIM_W          = 8,
   parameter int AVG_LOG2_MAX     = 3
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   dac_sampler_mc_if.master bus
);
   localparam int AVG_W  = clog2(AVG_LOG2_MAX + 1);
   localparam int BLK_W  = AVG_LOG2_MAX + 1;
   localparam int ACC_W  = acc_width(ZMOD_DATA_SIZE, AVG_LOG2_MAX);
   localparam int DATA_W = NUM_CH * ZMOD_DATA_SIZE;

   logic [0:0]                  r_state;
   logic [0:0]                  w_state_next;
   logic                        w_active;
   logic                        w_flush;

   logic [DECIM_W-1:0]          r_dec_cnt;
   logic [BLK_W-1:0]            r_blk_cnt;
   logic [DECIM_W-1:0]          r_decim_l;
   logic [AVG_W-1:0]            r_avg_l;

   logic [AVG_W-1:0]            w_avg_in;
   logic [DECIM_W-1:0]          w_decim_eff;
   logic [AVG_W-1:0]            w_avg_eff;
   logic [DECIM_W-1:0]          w_reload;
   logic [BLK_W-1:0]            w_blk_next;
   logic [BLK_W-1:0]            w_blk_len;
   logic                        w_block_start;
   logic                        w_strobe;
   logic                        w_accept;
   logic                        w_complete;
   logic [DATA_W-1:0]           w_result;

   logic [DATA_W-1:0]           r_data;
   logic [IAGC_STATUS_SIZE-1:0] r_status;
   logic                        r_valid;
   logic                        r_overrun;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.i_enable)  w_state_next = ST_RUN;
         ST_RUN:  if (!bus.i_enable) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_active = 1'b0;
      w_flush  = 1'b0;
      if (r_state == ST_RUN) begin
         w_active = bus.i_enable;
         w_flush  = !bus.i_enable;
      end
   end

   // ---------------- Decimation / block control ----------------
   // At block start the live config applies immediately and is latched for
   // the rest of the block, so mid-block changes only affect the next one.
   assign w_block_start = (r_blk_cnt == '0);
   assign w_avg_in      = AVG_W'(clamp_log2(32'(bus.i_avg_log2), AVG_LOG2_MAX));
   assign w_decim_eff   = w_block_start ? bus.i_decim : r_decim_l;
   assign w_avg_eff     = w_block_start ? w_avg_in    : r_avg_l;
   assign w_reload      = (w_decim_eff == '0) ? '0 : w_decim_eff - DECIM_W'(1);

   assign w_strobe   = w_active & bus.i_sample;
   assign w_accept   = w_strobe & (r_dec_cnt == '0);
   assign w_blk_next = r_blk_cnt + BLK_W'(1);
   assign w_blk_len  = BLK_W'(1) << w_avg_eff;
   assign w_complete = w_accept & (w_blk_next == w_blk_len);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_dec_cnt <= '0;
         r_blk_cnt <= '0;
         r_decim_l <= '0;
         r_avg_l   <= '0;
      end else if (w_flush) begin
         r_dec_cnt <= '0;
         r_blk_cnt <= '0;
      end else if (w_accept) begin
         r_dec_cnt <= w_reload;
         r_blk_cnt <= w_complete ? '0 : w_blk_next;
         if (w_block_start) begin
            r_decim_l <= bus.i_decim;
            r_avg_l   <= w_avg_in;
         end
      end else if (w_strobe) begin
         r_dec_cnt <= r_dec_cnt - DECIM_W'(1);
      end
   end

   // ---------------- Per-channel averaging ----------------
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      dac_avg_channel #(
         .DATA_W  (ZMOD_DATA_SIZE),
         .ACC_W   (ACC_W),
         .SHIFT_W (AVG_W)
      ) u_ch (
         .clk        (i_clock),
         .rst_n      (i_reset_n),
         .clear      (w_flush),
         .accumulate (w_accept),
         .complete   (w_complete),
         .shift      (w_avg_eff),
         .sample     (bus.i_data[k*ZMOD_DATA_SIZE +: ZMOD_DATA_SIZE]),
         .result     (w_result[k*ZMOD_DATA_SIZE +: ZMOD_DATA_SIZE])
      );
   end

   // ---------------- Result register and handshake ----------------
   // A new result always wins; losing an unaccepted one raises sticky overrun.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_data    <= '0;
         r_status  <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_complete) begin
            r_data   <= w_result;
            r_status <= bus.i_iagc_status;
            r_valid  <= 1'b1;
         end else if (r_valid && bus.i_ready) begin
            r_valid  <= 1'b0;
         end

         if (w_complete && r_valid && !bus.i_ready) begin
            r_overrun <= 1'b1;
         end else if (bus.i_clear_overrun) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign bus.o_data        = r_data;
   assign bus.o_iagc_status = r_status;
   assign bus.o_valid       = r_valid;
   assign bus.o_overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_dac_sampler_mc.sv
// ============================================================================
// Module      : tb_dac_sampler_mc
// Description : Self-checking bench for dac_sampler_mc: vector table,
//               directed corner sequences and random traffic against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_sampler_mc;
   localparam int Z  = 14;
   localparam int S  = 4;
   localparam int N  = 2;
   localparam int D  = 8;
   localparam int AM = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dac_sampler_mc_if #(.ZMOD_DATA_SIZE(Z), .IAGC_STATUS_SIZE(S), .NUM_CH(N),
                       .DECIM_W(D), .AVG_LOG2_MAX(AM)) bus ();

   dac_sampler_mc #(.ZMOD_DATA_SIZE(Z), .IAGC_STATUS_SIZE(S), .NUM_CH(N),
                    .DECIM_W(D), .AVG_LOG2_MAX(AM)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   bit          m_run;
   int          m_skip, m_cnt, m_L, m_decim;
   int          m_sum [N];
   bit          m_valid, m_ovr;
   logic [Z-1:0] m_data [N];
   logic [S-1:0] m_st;

   function automatic int sx(input logic [Z-1:0] v);
      return int'($signed(v));
   endfunction

   task automatic model_reset();
      m_run = 0; m_skip = 0; m_cnt = 0; m_L = 0; m_decim = 0;
      m_valid = 0; m_ovr = 0; m_st = '0;
      for (int c = 0; c < N; c++) begin m_sum[c] = 0; m_data[c] = '0; end
   endtask

   // One clock edge of the specified behaviour, using the inputs now on the bus.
   task automatic model_edge();
      bit           done;
      logic [Z-1:0] res [N];
      done = 0;
      for (int c = 0; c < N; c++) res[c] = '0;
      if (m_run && bus.i_enable && bus.i_sample) begin
         if (m_skip == 0) begin
            if (m_cnt == 0) begin
               m_decim = int'(bus.i_decim);
               m_L     = (int'(bus.i_avg_log2) > AM) ? AM : int'(bus.i_avg_log2);
            end
            for (int c = 0; c < N; c++) m_sum[c] += sx(bus.i_data[c*Z +: Z]);
            m_cnt++;
            m_skip = ((m_decim == 0) ? 1 : m_decim) - 1;
            if (m_cnt == (1 << m_L)) begin
               done = 1;
               for (int c = 0; c < N; c++) begin
                  res[c]   = Z'(m_sum[c] >>> m_L);
                  m_sum[c] = 0;
               end
               m_cnt = 0;
            end
         end else begin
            m_skip--;
         end
      end
      if (m_run && !bus.i_enable) begin
         m_skip = 0; m_cnt = 0;
         for (int c = 0; c < N; c++) m_sum[c] = 0;
      end
      m_run = bus.i_enable;
      if (done) begin
         if (m_valid && !bus.i_ready) m_ovr = 1;
         else if (bus.i_clear_overrun) m_ovr = 0;
         m_valid = 1;
         for (int c = 0; c < N; c++) m_data[c] = res[c];
         m_st = bus.i_iagc_status;
      end else begin
         if (m_valid && bus.i_ready) m_valid = 0;
         if (bus.i_clear_overrun) m_ovr = 0;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("valid",   32'(bus.o_valid),       32'(m_valid));
      check("overrun", 32'(bus.o_overrun),     32'(m_ovr));
      check("data",    32'(bus.o_data),        32'({m_data[1], m_data[0]}));
      check("status",  32'(bus.o_iagc_status), 32'(m_st));
   endtask

   task automatic step(input bit en, input bit smp, input bit rdy, input bit clr,
                       input logic [Z-1:0] c0, input logic [Z-1:0] c1,
                       input logic [S-1:0] st, input int decim, input int avg);
      @(negedge clk);
      bus.i_enable        = en;
      bus.i_sample        = smp;
      bus.i_ready         = rdy;
      bus.i_clear_overrun = clr;
      bus.i_data          = {c1, c0};
      bus.i_iagc_status   = st;
      bus.i_decim         = D'(decim);
      bus.i_avg_log2      = 2'(avg);
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit           en, smp, rdy;
      logic [Z-1:0] c0, c1;
      int           decim, avg;
      bit           ev;
      logic [Z-1:0] e0, e1;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{1, 0, 1, 14'h0000, 14'h0000, 1, 0, 0, 14'h0000, 14'h0000};
      tbl[1] = '{1, 1, 1, 14'h1234, 14'h0ABC, 1, 0, 1, 14'h1234, 14'h0ABC};
      tbl[2] = '{1, 0, 1, 14'h0000, 14'h0000, 1, 0, 0, 14'h0000, 14'h0000};
      tbl[3] = '{1, 1, 1, 14'h3FFD, 14'h0005, 1, 1, 0, 14'h0000, 14'h0000};
      tbl[4] = '{1, 1, 1, 14'h3FFE, 14'h0006, 1, 1, 1, 14'h3FFD, 14'h0005};
      tbl[5] = '{1, 0, 1, 14'h0000, 14'h0000, 1, 1, 0, 14'h0000, 14'h0000};

      bus.i_enable = 0; bus.i_sample = 0; bus.i_ready = 0; bus.i_clear_overrun = 0;
      bus.i_data = '0; bus.i_iagc_status = '0; bus.i_decim = '0; bus.i_avg_log2 = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_valid", 32'(bus.o_valid), 32'd0);
      check("reset_data",  32'(bus.o_data),  32'd0);
      rst_n = 1'b1;

      // Hold mode and signed floor averaging
      for (int i = 0; i < 6; i++) begin
         step(tbl[i].en, tbl[i].smp, tbl[i].rdy, 0, tbl[i].c0, tbl[i].c1, S'(i),
              tbl[i].decim, tbl[i].avg);
         check("tbl_valid", 32'(bus.o_valid), 32'(tbl[i].ev));
         if (tbl[i].ev) check("tbl_data", 32'(bus.o_data), 32'({tbl[i].e1, tbl[i].e0}));
      end

      // Decimate by 3, average 4: accepted strobes 1,4,7,10
      for (int k = 1; k <= 10; k++) begin
         step(1, 1, 1, 0, (k % 3 == 1) ? Z'(4 * ((k + 2) / 3)) : Z'(99), '0, 4'h7, 3, 2);
         check("decim_valid", 32'(bus.o_valid), 32'(k == 10));
      end
      check("decim_ch0", 32'(bus.o_data[Z-1:0]), 32'd10);

      // Drain the decimation countdown (2 strobes), then average 8 at max exponent
      step(1, 1, 1, 0, Z'(500), Z'(500), '0, 1, 3);
      step(1, 1, 1, 0, Z'(500), Z'(500), '0, 1, 3);
      for (int k = 1; k <= 8; k++) begin
         step(1, 1, 1, 0, Z'(k), Z'(-k), 4'h9, 1, 3);
         check("avg8_valid", 32'(bus.o_valid), 32'(k == 8));
      end
      check("avg8_data", 32'(bus.o_data), 32'({14'h3FFB, 14'h0004}));

      // Backpressure and overrun
      step(1, 1, 0, 0, Z'(11), '0, '0, 1, 0);
      step(1, 1, 0, 0, Z'(22), '0, '0, 1, 0);
      check("ovr_set",  32'(bus.o_overrun), 32'd1);
      check("ovr_data", 32'(bus.o_data[Z-1:0]), 32'd22);
      step(1, 0, 0, 1, '0, '0, '0, 1, 0);
      check("ovr_clear", 32'(bus.o_overrun), 32'd0);
      step(1, 1, 1, 0, Z'(33), '0, '0, 1, 0);
      check("accept_load_valid", 32'(bus.o_valid), 32'd1);
      check("accept_load_ovr",   32'(bus.o_overrun), 32'd0);
      step(1, 1, 0, 1, Z'(44), '0, '0, 1, 0);
      check("set_beats_clear", 32'(bus.o_overrun), 32'd1);
      step(1, 0, 1, 1, '0, '0, '0, 1, 0);
      check("ovr_clear2", 32'(bus.o_overrun), 32'd0);
      check("drained",    32'(bus.o_valid),   32'd0);

      // Flush mid-block with a pending result
      step(1, 1, 0, 0, Z'(55), '0, '0, 1, 0);
      step(1, 1, 0, 0, Z'(100), '0, '0, 1, 2);
      step(1, 1, 0, 0, Z'(200), '0, '0, 1, 2);
      step(0, 1, 0, 0, Z'(300), '0, '0, 1, 2);
      check("flush_keeps_valid", 32'(bus.o_valid), 32'd1);
      check("flush_keeps_data",  32'(bus.o_data[Z-1:0]), 32'd55);
      step(0, 0, 1, 0, '0, '0, '0, 1, 2);
      check("idle_handshake", 32'(bus.o_valid), 32'd0);
      step(1, 1, 1, 0, Z'(999), '0, '0, 1, 2);
      for (int k = 1; k <= 4; k++) step(1, 1, 1, 0, Z'(4 * k), '0, '0, 1, 2);
      check("flush_result_valid", 32'(bus.o_valid), 32'd1);
      check("flush_result",       32'(bus.o_data[Z-1:0]), 32'd10);

      // Asynchronous reset mid-block with valid and overrun set
      step(1, 1, 0, 0, Z'(1), '0, 4'hF, 1, 0);
      step(1, 1, 0, 0, Z'(2), '0, 4'hF, 1, 0);
      step(1, 1, 0, 0, Z'(7), '0, 4'hF, 1, 2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_valid",   32'(bus.o_valid),       32'd0);
      check("async_overrun", 32'(bus.o_overrun),     32'd0);
      check("async_data",    32'(bus.o_data),        32'd0);
      check("async_status",  32'(bus.o_iagc_status), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 1, 0, '0, '0, '0, 1, 2);
      for (int k = 1; k <= 4; k++) step(1, 1, 1, 0, Z'(k == 4 ? 6 : k), '0, '0, 1, 2);
      check("post_reset_valid", 32'(bus.o_valid), 32'd1);
      check("post_reset_data",  32'(bus.o_data[Z-1:0]), 32'd3);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
              $urandom_range(0, 7) == 0, Z'($urandom), Z'($urandom), S'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
